universal_ff_reg: RTL

UNIVERSAL_FF_REG -- requirements
Module: universal_ff_reg

---
 rtl/uff_pkg.sv | 14 +
 rtl/jk_bit_cell.sv | 30 +++
 rtl/universal_ff_reg.sv | 88 ++++++++
 3 files changed

// File: rtl/uff_pkg.sv
// Shared op encoding for the universal flip-flop register.
// Ops 100/101 are shifts only when UFF_SHIFT_EN is defined; otherwise they act as HOLD.
package uff_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_LOAD   = 3'b001,
    OP_JK     = 3'b010,
    OP_TOGGLE = 3'b011,
    OP_SHL    = 3'b100,
    OP_SHR    = 3'b101
  } uff_op_t;

endpackage

// File: rtl/jk_bit_cell.sv
// One JK storage bit with a synchronous active-high reset to a per-bit value.
module jk_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= rst_val;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/universal_ff_reg.sv
// Universal register: every op (LOAD/JK/TOGGLE/shift) is expressed as J/K drive on a row of JK cells.
// Define UFF_SHIFT_EN to enable ops SHL/SHR and the ser_in port.
module universal_ff_reg
  import uff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
`ifdef UFF_SHIFT_EN
  input  logic             ser_in,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed
);

  logic [WIDTH-1:0] j_d, k_d, q_d;
  logic             diff_q, changed_q;

`ifdef UFF_SHIFT_EN
  logic [WIDTH-1:0] shl_src, shr_src;
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_src = ser_in;
      assign shr_src = ser_in;
    end else begin : g_wn
      assign shl_src = {q[WIDTH-2:0], ser_in};
      assign shr_src = {ser_in, q[WIDTH-1:1]};
    end
  endgenerate
`endif

  always_comb begin
    j_d = '0;
    k_d = '0;
    if (en) begin
      case (uff_op_t'(op))
        OP_LOAD:   begin j_d = d;       k_d = ~d;       end
        OP_JK:     begin j_d = j;       k_d = k;        end
        OP_TOGGLE: begin j_d = d;       k_d = d;        end
`ifdef UFF_SHIFT_EN
        OP_SHL:    begin j_d = shl_src; k_d = ~shl_src; end
        OP_SHR:    begin j_d = shr_src; k_d = ~shr_src; end
`endif
        default:   begin j_d = '0;      k_d = '0;       end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_bit_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_VAL[i]),
        .j       (j_d[i]),
        .k       (k_d[i]),
        .q       (q[i])
      );
    end
  endgenerate

  // Value the cells will take on this edge; only used to detect a change.
  assign q_d = (j_d & ~q) | (~k_d & q);

  // diff_q records "q changed on this edge"; changed_q republishes it one edge later.
  // A reset edge is not counted as a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      diff_q    <= (q_d != q);
      changed_q <= diff_q;
    end
  end

  assign qbar    = ~q;
  assign changed = changed_q;

endmodule
